// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Purpose:
//   Instruction-fetch stage of a simple ARM-style pipeline. Holds the program
//   counter, presents a word-aligned fetch address to a combinational
//   instruction memory, and registers the returned word together with its
//   address into the IF/ID pipeline register. Downstream can freeze the stage
//   (stall) or redirect it to a new target (redirect / redirect_pc).
//
//   Sequencing is a four-state machine:
//     BOOT  - single cycle after reset, no fetch, redirects ignored
//     RUN   - normal streaming fetch, one instruction per cycle
//     HELD  - entered on a stalled cycle; IF/ID and PC frozen while stall is
//             high, and streaming resumes in the first cycle stall is low
//     FLUSH - single cycle after a redirect; PC holds the new target and
//             IF/ID stays invalid, then fetch resumes (or holds on stall)
//
// Parameters:
//   RESET_PC    - first fetch address after reset (low two bits ignored)
//   IMEM_WORDS  - instruction memory depth in 32-bit words; fetches at or
//                 beyond IMEM_WORDS*4 are flagged via oob_d
//
// Ports:
//   clk          in   1   clock, all state updates on rising edge
//   reset        in   1   asynchronous active-high reset
//   stall        in   1   freeze PC and IF/ID register
//   redirect     in   1   branch / PC-write request (beats stall)
//   redirect_pc  in  32   branch target (low two bits cleared internally)
//   imem_addr    out 32   byte address to instruction memory
//   imem_rd      in  32   instruction word for imem_addr (combinational)
//   instr_d      out 32   registered instruction for decode
//   pc_d         out 32   registered address of instr_d
//   pc_plus8_d   out 32   pc_d + 8 (architectural PC read value)
//   valid_d      out  1   qualifies instr_d / pc_d
//   oob_d        out  1   pc_d lies at or beyond the end of instruction memory
//
// Optional feature (macro FETCH_PERF_COUNTERS_EN):
//   fetch_count  out 32   saturating count of cycles that load a valid fetch
//   bubble_count out 32   saturating count of cycles spent in BOOT/HELD/FLUSH
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter int unsigned IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus8_d,
  output logic        valid_d,
  output logic        oob_d
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  // End of instruction memory in bytes; one extra bit so the comparison
  // stays exact even for very large IMEM_WORDS values.
  localparam logic [32:0] LP_IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HELD  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] f_word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Sequential next PC; 32-bit addition wraps modulo 2^32 by construction.
  function automatic logic [31:0] f_pc_incr(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Architectural read value of the PC (two instructions ahead), wrapping.
  function automatic logic [31:0] f_pc_plus8(input logic [31:0] pc);
    return pc + 32'd8;
  endfunction

  // Fetch address falls outside the populated instruction memory.
  function automatic logic f_oob(input logic [31:0] pc);
    return ({1'b0, pc} >= LP_IMEM_BYTES);
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc_plus8_d;
  logic        r_valid_d;
  logic        r_oob_d;

  logic        w_take_redirect;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc_next;

  // A redirect only takes effect once the boot cycle has completed.
  assign w_take_redirect = redirect & (r_state != ST_BOOT);
  assign w_redirect_pc   = f_word_align(redirect_pc);
  assign w_pc_next       = f_pc_incr(r_pc);

  // Fetch address comes straight from the PC register (already aligned,
  // masked again so bits [1:0] are zero by construction).
  assign imem_addr = f_word_align(r_pc);

  // -------------------------------------------------------------------------
  // Fetch sequencing: PC, IF/ID register and state machine
  // -------------------------------------------------------------------------
  // Single registered FSM updating PC, IF/ID outputs and state together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_BOOT;
      r_pc         <= f_word_align(RESET_PC);
      r_instr_d    <= 32'h00000000;
      r_pc_d       <= 32'h00000000;
      r_pc_plus8_d <= 32'h00000008;  // tracks pc_d + 8 with pc_d = 0
      r_valid_d    <= 1'b0;
      r_oob_d      <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          // No fetch and no redirect in the boot cycle; PC stays at RESET_PC.
          r_state <= ST_RUN;
        end

        ST_RUN, ST_HELD: begin
          if (w_take_redirect) begin
            // Redirect beats stall; the in-flight IF/ID entry is squashed.
            r_pc      <= w_redirect_pc;
            r_valid_d <= 1'b0;
            r_state   <= ST_FLUSH;
          end else if (stall) begin
            // Everything holds; HELD records that this cycle was frozen.
            r_state <= ST_HELD;
          end else begin
            // Stream one instruction: imem_rd belongs to the current PC.
            r_instr_d    <= imem_rd;
            r_pc_d       <= r_pc;
            r_pc_plus8_d <= f_pc_plus8(r_pc);
            r_valid_d    <= 1'b1;
            r_oob_d      <= f_oob(r_pc);
            r_pc         <= w_pc_next;
            r_state      <= ST_RUN;
          end
        end

        ST_FLUSH: begin
          if (w_take_redirect) begin
            // Back-to-back redirect: newest target wins, flush restarts.
            r_pc      <= w_redirect_pc;
            r_valid_d <= 1'b0;
            r_state   <= ST_FLUSH;
          end else if (stall) begin
            r_state <= ST_HELD;
          end else begin
            r_state <= ST_RUN;
          end
        end

        default: begin
          // Unreachable encoding: recover through a clean boot cycle.
          r_state   <= ST_BOOT;
          r_valid_d <= 1'b0;
        end
      endcase
    end
  end

  assign instr_d    = r_instr_d;
  assign pc_d       = r_pc_d;
  assign pc_plus8_d = r_pc_plus8_d;
  assign valid_d    = r_valid_d;
  assign oob_d      = r_oob_d;

`ifdef FETCH_PERF_COUNTERS_EN
  // -------------------------------------------------------------------------
  // Performance counters
  // -------------------------------------------------------------------------

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] f_sat_inc(input logic [31:0] cnt);
    return (cnt == 32'hFFFFFFFF) ? cnt : (cnt + 32'd1);
  endfunction

  logic        w_fetch;
  logic        w_bubble;
  logic [31:0] r_fetch_count;
  logic [31:0] r_bubble_count;

  // Same condition that loads valid_d with 1 in the sequencing block.
  assign w_fetch  = ~w_take_redirect & ~stall &
                    ((r_state == ST_RUN) | (r_state == ST_HELD));
  assign w_bubble = (r_state == ST_BOOT) | (r_state == ST_HELD) |
                    (r_state == ST_FLUSH);

  // Saturating fetch and bubble counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_count  <= 32'h00000000;
      r_bubble_count <= 32'h00000000;
    end else begin
      if (w_fetch) begin
        r_fetch_count <= f_sat_inc(r_fetch_count);
      end else begin
        r_fetch_count <= r_fetch_count;
      end
      if (w_bubble) begin
        r_bubble_count <= f_sat_inc(r_bubble_count);
      end else begin
        r_bubble_count <= r_bubble_count;
      end
    end
  end

  assign fetch_count  = r_fetch_count;
  assign bubble_count = r_bubble_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage. A small behavioural model tracks the
// fetch stream as "PC, last delivered instruction, and whether the next cycle
// is a boot or flush bubble"; directed scenarios and a randomized run are
// compared cycle by cycle against it.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RPC   = 32'h00000000;
  localparam int unsigned WORDS = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus8_d;
  logic        valid_d;
  logic        oob_d;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Instruction memory image: 64 words populated, a fixed pattern beyond.
  logic [31:0] mem [0:63];
  assign imem_rd = (imem_addr < 32'd256) ? mem[imem_addr[7:2]]
                                         : (imem_addr ^ 32'h5A5A0F0F);

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC), .IMEM_WORDS(WORDS)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus8_d  (pc_plus8_d),
    .valid_d     (valid_d),
    .oob_d       (oob_d)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .fetch_count (fetch_count),
    .bubble_count(bubble_count)
`endif
  );

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_instr, m_pcd;
  logic        m_valid, m_oob;
  bit          m_boot, m_flush, m_bubble_now;
  longint      m_fetches, m_bubbles;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd256) return mem[a[7:2]];
    return a ^ 32'h5A5A0F0F;
  endfunction

  task automatic model_reset();
    m_pc = RPC & 32'hFFFFFFFC;
    m_instr = 32'd0; m_pcd = 32'd0; m_valid = 1'b0; m_oob = 1'b0;
    m_boot = 1'b1; m_flush = 1'b0; m_bubble_now = 1'b1;
    m_fetches = 0; m_bubbles = 0;
  endtask

  // Advance the model by one clock with this cycle's inputs.
  task automatic model_step(input logic s, input logic r, input logic [31:0] rpc);
    if (m_bubble_now) m_bubbles++;
    if (m_boot) begin
      m_boot = 1'b0; m_bubble_now = 1'b0;
    end else if (r) begin
      m_pc = rpc & 32'hFFFFFFFC; m_valid = 1'b0; m_flush = 1'b1; m_bubble_now = 1'b1;
    end else if (m_flush) begin
      m_flush = 1'b0; m_bubble_now = s;
    end else if (s) begin
      m_bubble_now = 1'b1;
    end else begin
      m_instr = mem_word(m_pc); m_pcd = m_pc; m_valid = 1'b1;
      m_oob = (m_pc >= WORDS * 4);
      m_pc = m_pc + 32'd4; m_fetches++; m_bubble_now = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, step the model, and land at posedge+1.
  task automatic apply(input logic s, input logic r, input logic [31:0] rpc);
    stall = s; redirect = r; redirect_pc = rpc;
    model_step(s, r, rpc);
    @(posedge clk); #1;
  endtask

  task automatic release_reset();
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    #12;
    vectors++;
    if ({valid_d, oob_d, instr_d, pc_d, pc_plus8_d, imem_addr} !==
        {1'b0, 1'b0, 32'd0, 32'd0, 32'd8, RPC}) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b o=%b i=%h pc=%h p8=%h a=%h, exp v=0 o=0 i=0 pc=0 p8=8 a=%h",
               valid_d, oob_d, instr_d, pc_d, pc_plus8_d, imem_addr, RPC);
    end
  endtask

  task automatic test_boot_latency();
    release_reset();
    apply(1'b0, 1'b0, 32'd0);
    vectors++;
    if (valid_d !== 1'b0 || imem_addr !== 32'd0) begin
      miscompares++;
      $display("FAIL boot_cycle: got v=%b a=%h, exp v=0 a=0", valid_d, imem_addr);
    end
    apply(1'b0, 1'b0, 32'd0);
    vectors++;
    if ({valid_d, instr_d, pc_d, pc_plus8_d, imem_addr} !==
        {1'b1, 32'hE04F000F, 32'd0, 32'd8, 32'd4}) begin
      miscompares++;
      $display("FAIL first_fetch: got v=%b i=%h pc=%h p8=%h a=%h, exp v=1 i=e04f000f pc=0 p8=8 a=4",
               valid_d, instr_d, pc_d, pc_plus8_d, imem_addr);
    end
  endtask

  task automatic test_stall();
    apply(1'b0, 1'b0, 32'd0);  // PC now 8, pc_d = 4
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, 1'b0, 32'd0);
      vectors++;
      if (imem_addr !== 32'd8 || pc_d !== 32'd4 || instr_d !== mem[1] || valid_d !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got a=%h pc=%h i=%h v=%b, exp a=8 pc=4 i=%h v=1",
                 k, imem_addr, pc_d, instr_d, valid_d, mem[1]);
      end
    end
    apply(1'b0, 1'b0, 32'd0);
    vectors++;
    if (pc_d !== 32'd8 || instr_d !== mem[2]) begin
      miscompares++;
      $display("FAIL stall_release1: got pc=%h i=%h, exp pc=8 i=%h", pc_d, instr_d, mem[2]);
    end
    apply(1'b0, 1'b0, 32'd0);
    vectors++;
    if (pc_d !== 32'd12) begin
      miscompares++;
      $display("FAIL stall_release2: got pc=%h, exp pc=c", pc_d);
    end
  endtask

  task automatic test_redirect_over_stall();
    apply(1'b1, 1'b1, 32'h47);
    vectors++;
    if (imem_addr !== 32'h44 || valid_d !== 1'b0) begin
      miscompares++;
      $display("FAIL redirect_stall: got a=%h v=%b, exp a=44 v=0", imem_addr, valid_d);
    end
    apply(1'b0, 1'b0, 32'd0);  // flush cycle, PC held
    vectors++;
    if (imem_addr !== 32'h44 || valid_d !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_hold: got a=%h v=%b, exp a=44 v=0", imem_addr, valid_d);
    end
    apply(1'b0, 1'b0, 32'd0);
    vectors++;
    if (pc_d !== 32'h44 || valid_d !== 1'b1 || instr_d !== mem[17]) begin
      miscompares++;
      $display("FAIL redirect_target: got pc=%h v=%b i=%h, exp pc=44 v=1 i=%h",
               pc_d, valid_d, instr_d, mem[17]);
    end
  endtask

  task automatic test_wrap();
    apply(1'b0, 1'b1, 32'hFFFFFFFC);
    apply(1'b0, 1'b0, 32'd0);
    apply(1'b0, 1'b0, 32'd0);
    vectors++;
    if ({pc_d, pc_plus8_d, imem_addr, oob_d, valid_d} !==
        {32'hFFFFFFFC, 32'd4, 32'd0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL wrap: got pc=%h p8=%h a=%h o=%b v=%b, exp pc=fffffffc p8=4 a=0 o=1 v=1",
               pc_d, pc_plus8_d, imem_addr, oob_d, valid_d);
    end
    apply(1'b0, 1'b0, 32'd0);
    vectors++;
    if (pc_d !== 32'd0 || oob_d !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_next: got pc=%h o=%b, exp pc=0 o=0", pc_d, oob_d);
    end
  endtask

  task automatic test_oob_boundary();
    apply(1'b0, 1'b1, 32'h000000F8);
    apply(1'b0, 1'b0, 32'd0);
    apply(1'b0, 1'b0, 32'd0);
    apply(1'b0, 1'b0, 32'd0);
    vectors++;
    if (pc_d !== 32'hFC || oob_d !== 1'b0) begin
      miscompares++;
      $display("FAIL oob_last_word: got pc=%h o=%b, exp pc=fc o=0", pc_d, oob_d);
    end
    apply(1'b0, 1'b0, 32'd0);
    vectors++;
    if (pc_d !== 32'h100 || oob_d !== 1'b1) begin
      miscompares++;
      $display("FAIL oob_first_out: got pc=%h o=%b, exp pc=100 o=1", pc_d, oob_d);
    end
  endtask

  task automatic test_boot_redirect_ignored();
    reset = 1'b1; #3;
    release_reset();
    apply(1'b0, 1'b1, 32'h80);  // boot cycle
    vectors++;
    if (imem_addr !== RPC || valid_d !== 1'b0) begin
      miscompares++;
      $display("FAIL boot_redirect: got a=%h v=%b, exp a=%h v=0", imem_addr, valid_d, RPC);
    end
    apply(1'b0, 1'b0, 32'd0);
    vectors++;
    if (pc_d !== RPC || valid_d !== 1'b1) begin
      miscompares++;
      $display("FAIL boot_redirect_fetch: got pc=%h v=%b, exp pc=%h v=1", pc_d, valid_d, RPC);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 4; k++) apply(1'b0, 1'b0, 32'd0);  // PC 4 -> 20
    vectors++;
    if (imem_addr !== 32'd20 || valid_d !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_pc: got a=%h v=%b, exp a=14 v=1", imem_addr, valid_d);
    end
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    #2; reset = 1'b1; #1;  // mid-cycle, no clock edge
    vectors++;
    if (valid_d !== 1'b0 || imem_addr !== RPC || pc_d !== 32'd0) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b a=%h pc=%h, exp v=0 a=%h pc=0",
               valid_d, imem_addr, pc_d, RPC);
    end
    release_reset();
    apply(1'b0, 1'b0, 32'd0);
    apply(1'b0, 1'b0, 32'd0);
    vectors++;
    if (pc_d !== RPC || valid_d !== 1'b1 || imem_addr !== RPC + 32'd4) begin
      miscompares++;
      $display("FAIL post_reset_fetch: got pc=%h v=%b a=%h, exp pc=%h v=1", pc_d, valid_d, imem_addr, RPC);
    end
  endtask

  task automatic test_random();
    logic s, r;
    logic [31:0] rpc;
    for (int n = 0; n < 400; n++) begin
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 7) == 0);
      rpc = ($urandom_range(0, 9) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 32'h140));
      apply(s, r, rpc);
      vectors++;
      if ({imem_addr, instr_d, pc_d, pc_plus8_d, valid_d, oob_d} !==
          {m_pc, m_instr, m_pcd, m_pcd + 32'd8, m_valid, m_oob}) begin
        miscompares++;
        $display("FAIL random[%0d]: got a=%h i=%h pc=%h p8=%h v=%b o=%b, exp a=%h i=%h pc=%h p8=%h v=%b o=%b",
                 n, imem_addr, instr_d, pc_d, pc_plus8_d, valid_d, oob_d,
                 m_pc, m_instr, m_pcd, m_pcd + 32'd8, m_valid, m_oob);
      end
    end
  endtask

`ifdef FETCH_PERF_COUNTERS_EN
  task automatic test_perf_counters();
    reset = 1'b1; #3;
    release_reset();
    apply(1'b0, 1'b0, 32'd0);                           // boot
    for (int k = 0; k < 5; k++) apply(1'b0, 1'b0, 32'd0);
    for (int k = 0; k < 2; k++) apply(1'b1, 1'b0, 32'd0);
    for (int k = 0; k < 3; k++) apply(1'b0, 1'b0, 32'd0);
    apply(1'b0, 1'b1, 32'h40);
    for (int k = 0; k < 2; k++) apply(1'b0, 1'b0, 32'd0);
    vectors++;
    if (fetch_count !== 32'd9 || bubble_count !== 32'd4) begin
      miscompares++;
      $display("FAIL perf_counters: got fetch=%0d bubble=%0d, exp fetch=9 bubble=4",
               fetch_count, bubble_count);
    end
    vectors++;
    if (fetch_count !== 32'(m_fetches) || bubble_count !== 32'(m_bubbles)) begin
      miscompares++;
      $display("FAIL perf_model: got fetch=%0d bubble=%0d, exp fetch=%0d bubble=%0d",
               fetch_count, bubble_count, m_fetches, m_bubbles);
    end
  endtask
`endif

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = $urandom;
    mem[0] = 32'hE04F000F;
    test_reset();
    test_boot_latency();
    test_stall();
    test_redirect_over_stall();
    test_wrap();
    test_oob_boundary();
    test_boot_redirect_ignored();
    test_async_reset();
    test_random();
`ifdef FETCH_PERF_COUNTERS_EN
    test_perf_counters();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 64, meaning the instruction memory depth in 32-bit words.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port stall, input, 1, freezing PC and the IF/ID register while high.
REQ-006 SHALL have port redirect, input, 1, branch/PC-write request from downstream.
REQ-007 SHALL have port redirect_pc, input, 32, the branch target.
REQ-008 SHALL have port imem_addr, output, 32, the byte address to the instruction memory.
REQ-009 SHALL have port imem_rd, input, 32, the instruction word returned combinationally for imem_addr.
REQ-010 SHALL have port instr_d, output, 32, the registered instruction to decode.
REQ-011 SHALL have port pc_d, output, 32, the registered address of instr_d.
REQ-012 SHALL have port pc_plus8_d, output, 32, pc_d+8, the ARM architectural PC read value.
REQ-013 SHALL have port valid_d, output, 1, qualifying instr_d/pc_d.
REQ-014 SHALL have port oob_d, output, 1, set when pc_d >= IMEM_WORDS*4.

Function
REQ-015 SHALL drive imem_addr combinationally from the internal PC register, with bits [1:0] always 0.
REQ-016 SHALL implement states BOOT, RUN, HELD and FLUSH.
REQ-017 BOOT SHALL be entered on reset and SHALL last exactly one cycle with valid_d=0, then go to RUN; PC is not advanced in BOOT.
REQ-018 In RUN with stall=0 and redirect=0, each cycle SHALL load instr_d<=imem_rd, pc_d<=PC, valid_d<=1 and PC<=PC+4, giving one-cycle fetch latency.
REQ-019 stall=1 with redirect=0 SHALL go to HELD and keep PC, instr_d, pc_d and valid_d unchanged; stall=0 SHALL return to RUN on the next cycle.
REQ-020 redirect=1 SHALL take priority over stall, load PC<=redirect_pc with bits [1:0] cleared, set valid_d<=0, and go to FLUSH from any state except BOOT.
REQ-021 FLUSH SHALL last one cycle, during which PC is held, then go to RUN, or to HELD if stall=1; a redirect in FLUSH SHALL reload PC and stay in FLUSH.
REQ-022 A redirect in BOOT SHALL be ignored.
REQ-023 PC+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 0).
REQ-024 pc_plus8_d SHALL be pc_d+8, wrapping modulo 2^32.
REQ-025 oob_d SHALL be registered with pc_d and SHALL NOT alter sequencing.

Reset
REQ-026 While reset=1 the block SHALL set PC=RESET_PC, instr_d=0, pc_d=0, valid_d=0, oob_d=0 and state=BOOT, independent of clk.
REQ-027 Reset asserted mid-operation SHALL discard any pending redirect or stall effect immediately.

Configuration
REQ-028 With macro FETCH_PERF_COUNTERS_EN defined, the block SHALL add 32-bit outputs fetch_count, which increments on each cycle valid_d is loaded with 1, and bubble_count, which increments on each cycle in BOOT, HELD or FLUSH.
REQ-029 Both counters SHALL reset to 0, saturate at 32'hFFFFFFFF, and be absent from the port list when the macro is undefined.

Verification
REQ-030 Release reset with RESET_PC=0 and imem_rd returning 32'hE04F000F at addr 0: cycle 1 has valid_d=0; cycle 2 has instr_d=32'hE04F000F, pc_d=0, pc_plus8_d=8 and imem_addr=4.
REQ-031 stall high for 3 cycles at PC=8: imem_addr stays 8 and instr_d/pc_d stay frozen; after release, pc_d=8 then 12.
REQ-032 redirect=1, redirect_pc=32'h47 together with stall=1: next cycle PC=32'h44 and valid_d=0; the following cycle with stall=0 gives pc_d=32'h44, valid_d=1.
REQ-033 Set PC to 32'hFFFFFFFC via redirect, then run: pc_d=32'hFFFFFFFC, pc_plus8_d=4, next imem_addr=0, oob_d=1.
REQ-034 Assert reset asynchronously mid-RUN at PC=20: valid_d=0 and imem_addr=RESET_PC without a clock edge.
REQ-035 With FETCH_PERF_COUNTERS_EN, apply 10 run cycles, 2 stall cycles and 1 redirect after boot: fetch_count=9 and bubble_count=4 (boot 1, stall 2, flush 1).
